// File: rtl/wptr_full_sync.sv
// wptr_full_sync
// Write-domain pointer and status block of the asynchronous FIFO.
// It brings the Gray-coded read pointer into wclk through a SYNC_STAGES-deep
// flop chain. It also generates the write pointer, both as binary (RAM address)
// and as Gray (sent to the read domain). It registers full, almost-full, the
// free-slot count and a sticky overflow flag.
//
// Optional feature: define SYNC_GRAY_CHECK_EN to build a checker on the
// synchronized read pointer. The checker flags any step that changes more than
// one bit. The flag is wgray_err, and it stays set until reset. With the macro
// undefined, wgray_err is tied to 0.
//
// Parameters:
//   ADDR_WIDTH   : RAM address width (>= 2), depth D = 2**ADDR_WIDTH
//   SYNC_STAGES  : flops in the rptr synchronizer (>= 2)
//   AFULL_THRESH : walmost_full when free count <= this value (0..D)
// Ports:
//   wclk, wrstn   : write clock, async active-low reset
//   winc          : write request
//   wovf_clr      : synchronous clear of woverflow
//   rptr          : Gray read pointer from the rclk domain
//   wptr          : registered Gray write pointer to the rclk domain
//   waddr         : RAM write address (low bits of binary write pointer)
//   wq_rptr       : synchronized read pointer (last sync stage)
//   wfull         : registered full flag
//   walmost_full  : registered almost-full flag
//   wfree         : registered free-slot count, 0..D
//   woverflow     : sticky, write attempted while full
//   wgray_err     : sticky, multi-bit step seen on wq_rptr (feature build only)

module wptr_full_sync #(
  parameter int ADDR_WIDTH   = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 1
) (
  input  logic                  wclk,
  input  logic                  wrstn,
  input  logic                  winc,
  input  logic                  wovf_clr,
  input  logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wq_rptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wfree,
  output logic                  woverflow,
  output logic                  wgray_err
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] AFULL_T   = PW'(AFULL_THRESH);
  localparam logic          AFULL_RST = (DEPTH <= AFULL_T);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_n;
  logic [PW-1:0] wgray_n;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] used_n;
  logic [PW-1:0] free_n;
  logic          wen;
  logic          full_n;
  logic          afull_n;

  // Read-pointer synchronizer chain; only the last stage is used downstream
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wq_rptr = sync_q[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_s[i] = ^(wq_rptr >> i);
    end
  end

  // Next-state pointer and status; the status is derived from the post-write
  // pointer so that a write is reflected in the same edge that accepts it
  always_comb begin
    wen     = winc & ~wfull;
    wbin_n  = wbin + {{ADDR_WIDTH{1'b0}}, wen};
    wgray_n = (wbin_n >> 1) ^ wbin_n;
    used_n  = wbin_n - rbin_s;
    free_n  = DEPTH - used_n;
    full_n  = (wgray_n == {~wq_rptr[PW-1:PW-2], wq_rptr[PW-3:0]});
    afull_n = (free_n <= AFULL_T);
  end

  assign waddr = wbin[ADDR_WIDTH-1:0];

  // Pointer and status registers
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wbin         <= '0;
      wptr         <= '0;
      wfree        <= DEPTH;
      wfull        <= 1'b0;
      walmost_full <= AFULL_RST;
    end else begin
      wbin         <= wbin_n;
      wptr         <= wgray_n;
      wfree        <= free_n;
      wfull        <= full_n;
      walmost_full <= afull_n;
    end
  end

  // Sticky overflow; a new overflow takes priority over a clear in the same cycle
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      woverflow <= 1'b0;
    end else begin
      woverflow <= (winc & wfull) | (woverflow & ~wovf_clr);
    end
  end

`ifdef SYNC_GRAY_CHECK_EN
  logic [PW-1:0] wq_prev;
  logic [PW-1:0] wq_diff;
  logic          gray_bad;

  // More than one differing bit means diff has a bit left after clearing its lowest set bit
  assign wq_diff  = wq_rptr ^ wq_prev;
  assign gray_bad = ((wq_diff & (wq_diff - PW'(1))) != '0);

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wq_prev   <= '0;
      wgray_err <= 1'b0;
    end else begin
      wq_prev <= wq_rptr;
      if (gray_bad) begin
        wgray_err <= 1'b1;
      end
    end
  end
`else
  assign wgray_err = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_sync.sv
// tb_wptr_full_sync
// Randomized self-checking bench for wptr_full_sync (ADDR_WIDTH=3,
// SYNC_STAGES=2, AFULL_THRESH=1). The reference model counts accepted writes
// and reads as plain integers. The read count reaches the status after a
// delay of a few edges. The driver pushes expected post-edge values into a
// scoreboard queue, and a monitor pops and compares them after each edge.
// Define SYNC_GRAY_CHECK_EN to also exercise the Gray-step checker.

module tb_wptr_full_sync;

  localparam int AW = 3;
  localparam int SS = 2;
  localparam int AT = 1;
  localparam int D  = 8;

  logic        wclk = 1'b0;
  logic        wrstn;
  logic        winc;
  logic        wovf_clr;
  logic [3:0]  rptr;
  logic [3:0]  wptr;
  logic [2:0]  waddr;
  logic [3:0]  wq_rptr;
  logic        wfull;
  logic        walmost_full;
  logic [3:0]  wfree;
  logic        woverflow;
  logic        wgray_err;

  wptr_full_sync #(
    .ADDR_WIDTH(AW),
    .SYNC_STAGES(SS),
    .AFULL_THRESH(AT)
  ) dut (
    .wclk(wclk),
    .wrstn(wrstn),
    .winc(winc),
    .wovf_clr(wovf_clr),
    .rptr(rptr),
    .wptr(wptr),
    .waddr(waddr),
    .wq_rptr(wq_rptr),
    .wfull(wfull),
    .walmost_full(walmost_full),
    .wfree(wfree),
    .woverflow(woverflow),
    .wgray_err(wgray_err)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic [3:0] wq;
    logic       full;
    logic       afull;
    logic [3:0] free;
    logic       ovf;
    logic       gerr;
    bit         chk_all;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;

  int         m_wr;
  int         rd_cnt;
  bit         m_full;
  bit         m_ovf;
  bit         m_gerr;
  int         rd_hist[$];
  logic [3:0] raw_hist[$];

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] b;
    b = 4'(n % 16);
    return b ^ (b >> 1);
  endfunction

  function automatic exp_t resetExp();
    exp_t e;
    e.wptr    = 4'd0;
    e.waddr   = 3'd0;
    e.wq      = 4'd0;
    e.full    = 1'b0;
    e.afull   = (D <= AT);
    e.free    = 4'(D);
    e.ovf     = 1'b0;
    e.gerr    = 1'b0;
    e.chk_all = 1'b1;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic modelReset();
    m_wr   = 0;
    rd_cnt = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_gerr = 1'b0;
    rd_hist.delete();
    raw_hist.delete();
    for (int i = 0; i < SS + 2; i++) begin
      rd_hist.push_back(0);
      raw_hist.push_back(4'd0);
    end
  endtask

  // Predict the state after the coming edge and queue it.
  // History index 0 holds this cycle's input. Index SS-1 is what wq_rptr shows
  // after the edge. Index SS is what wq_rptr showed before the edge, which is
  // the value the status logic uses.
  task automatic modelStep(input bit inc, input bit clr, input logic [3:0] raw, input bit chk_all);
    exp_t e;
    bit   acc;
    int   used;
    int   fr;
    acc   = inc && !m_full;
    m_ovf = (inc && m_full) || (m_ovf && !clr);
    if (acc) m_wr++;
    rd_hist.push_front(rd_cnt);
    void'(rd_hist.pop_back());
    raw_hist.push_front(raw);
    void'(raw_hist.pop_back());
`ifdef SYNC_GRAY_CHECK_EN
    if ($countones(raw_hist[SS] ^ raw_hist[SS+1]) > 1) m_gerr = 1'b1;
`endif
    used      = m_wr - rd_hist[SS];
    fr        = D - used;
    m_full    = (fr == 0);
    e.wptr    = to_gray(m_wr);
    e.waddr   = 3'(m_wr % 8);
    e.wq      = raw_hist[SS-1];
    e.full    = m_full;
    e.afull   = (fr <= AT);
    e.free    = 4'(fr);
    e.ovf     = m_ovf;
    e.gerr    = m_gerr;
    e.chk_all = chk_all;
    sb.push_back(e);
  endtask

  task automatic driveNow(input bit inc, input bit clr, input bit rd_step);
    if (rd_step && rd_cnt < m_wr) rd_cnt++;
    winc     = inc;
    wovf_clr = clr;
    rptr     = to_gray(rd_cnt);
    modelStep(inc, clr, rptr, 1'b1);
  endtask

  task automatic applyStimulus(input bit inc, input bit clr, input bit rd_step);
    @(negedge wclk);
    driveNow(inc, clr, rd_step);
  endtask

  task automatic applyRaw(input logic [3:0] raw);
    @(negedge wclk);
    winc     = 1'b0;
    wovf_clr = 1'b0;
    rptr     = raw;
    modelStep(1'b0, 1'b0, raw, 1'b0);
  endtask

  // Async reset mid-operation: outputs must clear before any clock edge
  task automatic doReset();
    @(negedge wclk);
    wrstn = 1'b0;
    #1;
    chk("async_rst_wptr", wptr, 0);
    chk("async_rst_wfree", wfree, D);
    chk("async_rst_wfull", wfull, 0);
    chk("async_rst_wovf", woverflow, 0);
    chk("async_rst_wq_rptr", wq_rptr, 0);
    chk("async_rst_wgray_err", wgray_err, 0);
    modelReset();
    winc     = 1'b0;
    wovf_clr = 1'b0;
    rptr     = 4'd0;
    @(negedge wclk);
    sb.push_back(resetExp());
    @(negedge wclk);
    wrstn = 1'b1;
    driveNow(1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    chk("wptr", wptr, e.wptr);
    chk("waddr", waddr, e.waddr);
    chk("wq_rptr", wq_rptr, e.wq);
    chk("woverflow", woverflow, e.ovf);
    chk("wgray_err", wgray_err, e.gerr);
    if (e.chk_all) begin
      chk("wfull", wfull, e.full);
      chk("walmost_full", walmost_full, e.afull);
      chk("wfree", wfree, e.free);
      chk("full_iff_free0", wfull, (wfree == 4'd0));
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge wclk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wrstn    = 1'b0;
    winc     = 1'b0;
    wovf_clr = 1'b0;
    rptr     = 4'd0;
    modelReset();
    repeat (2) begin
      @(negedge wclk);
      sb.push_back(resetExp());
    end
    @(negedge wclk);
    wrstn = 1'b1;
    driveNow(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 99) < 60,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 99) < 55);
    end
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 1'b1);

    doReset();
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);

`ifdef SYNC_GRAY_CHECK_EN
    doReset();
    repeat (5) applyRaw(4'b0011);
    doReset();
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
`endif

    @(posedge wclk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wptr_full_sync.md
# wptr_full_sync

Write-domain pointer and status block for the asynchronous FIFO. It carries the read-pointer synchronizer with a configurable number of flop stages and generalises it with write-pointer generation (binary and Gray), a registered full flag, a programmable almost-full flag, a free-slot count and a sticky overflow flag. It sits in the wclk domain between the writer, the dual-port RAM write port and the read-domain pointer logic.

## Interface
- ADDR_WIDTH, 3: RAM address width. Depth D = 2**ADDR_WIDTH. Legal range is ADDR_WIDTH >= 2.
- SYNC_STAGES, 2: number of flops in the rptr synchronizer chain. Legal range is >= 2.
- AFULL_THRESH, 1: walmost_full asserts when the free count is <= this value. Legal range is 0..D.
- wclk  in  1  write clock.
- wrstn  in  1  reset, asynchronous, active-low.
- winc  in  1  write request for this cycle.
- wovf_clr  in  1  synchronous clear of woverflow.
- rptr  in  ADDR_WIDTH+1  read pointer, Gray-coded, from the rclk domain.
- wptr  out  ADDR_WIDTH+1  write pointer, Gray-coded, registered. Sent to the read domain.
- waddr  out  ADDR_WIDTH  RAM write address. Equals the low bits of the binary write pointer.
- wq_rptr  out  ADDR_WIDTH+1  synchronized rptr, taken from the last synchronizer stage.
- wfull  out  1  FIFO full, registered.
- walmost_full  out  1  free count <= AFULL_THRESH, registered.
- wfree  out  ADDR_WIDTH+1  free slots, in the range 0..D, registered.
- woverflow  out  1  sticky flag: a write was attempted while full.
- wgray_err  out  1  sticky flag: Gray-sequence violation on wq_rptr. Present only when SYNC_GRAY_CHECK_EN is defined.

## Operation
- Synchronizer: the stage chain is sync[0] <= rptr, then sync[i] <= sync[i-1]. wq_rptr = sync[SYNC_STAGES-1].
- The write pointer is kept in binary as wbin, width ADDR_WIDTH+1, and wraps modulo 2**(ADDR_WIDTH+1).
- Write accept: wen = winc & ~wfull.
- Next pointer: wbin_n = wbin + wen, and wgray_n = (wbin_n >> 1) ^ wbin_n.
- Synchronized read pointer in binary: rbin_s = Gray-to-binary(wq_rptr), computed combinationally as an XOR prefix from the MSB.
- Used count: used_n = (wbin_n - rbin_s) mod 2**(ADDR_WIDTH+1).
- Registered on every wclk edge:
  - wbin <= wbin_n
  - wptr <= wgray_n
  - wfree <= D - used_n
  - wfull <= (wgray_n == {~wq_rptr[MSB:MSB-1], wq_rptr[MSB-2:0]})
  - walmost_full <= (D - used_n) <= AFULL_THRESH
- wfull == 1 if and only if wfree == 0. The bench must check this invariant every cycle.
- Overflow: winc & wfull sets woverflow on the next edge. The write is dropped and the pointer does not move.
- wovf_clr clears woverflow on the next edge. If wovf_clr and a new overflow occur in the same cycle, set wins.
- Reset values: sync[*]=0, wbin=0, wptr=0, waddr=0, wq_rptr=0, wfull=0, wfree=D, walmost_full=(D <= AFULL_THRESH), woverflow=0, wgray_err=0.
- wrstn asserted mid-operation clears all of the above immediately, with no clock needed. Deassertion is taken synchronously to wclk by the parent reset synchronizer.

## Timing
- A change on rptr is visible on wq_rptr after SYNC_STAGES wclk edges. It is reflected in wfull, wfree and walmost_full one edge after that (SYNC_STAGES+1 edges in total).
- An accepted write at edge k updates wptr, waddr, wfull and wfree at edge k. The next cycle therefore already sees the new status. waddr presented in the cycle of the write is the pre-increment address.
- Full is pessimistic: reads become visible late, so full and low-free readings are never optimistic.
- Pointer wrap (wbin going from 2**(ADDR_WIDTH+1)-1 to 0) needs no special handling. Modular subtraction keeps used_n correct.
- If a write and an incoming read-pointer update land in the same cycle, both are reflected in the same registered status.

## Configuration
- SYNC_GRAY_CHECK_EN defined:
  - Each cycle, the block compares wq_rptr with its previous value.
  - If more than one bit differs, wgray_err is set on the next edge and stays sticky until reset.
  - A change of zero bits or one bit is legal.
- SYNC_GRAY_CHECK_EN undefined:
  - The compare logic is not built.
  - The wgray_err port is still present and is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use ADDR_WIDTH=3, SYNC_STAGES=2, AFULL_THRESH=1.
- Reset -> wfree=8, wfull=0, walmost_full=0, wptr=0, woverflow=0.
- Eight back-to-back winc with rptr=0 -> wfree counts 7..0. walmost_full asserts when wfree reaches 1. wfull=1 after the 8th write. wptr=4'b1100.
- While full, winc=1 for one cycle -> woverflow=1, wptr unchanged. Then wovf_clr=1 -> woverflow=0 on the next edge.
- While full, drive rptr=4'b0001 -> wq_rptr=0001 after 2 edges. wfull=0 and wfree=1 on the 3rd edge.
- Drive wrap traffic: 20 writes with matched reads -> wbin wraps past 15. The wfull/wfree invariant holds and there is no spurious full.
- With SYNC_GRAY_CHECK_EN defined, step rptr 0000 -> 0011 -> wgray_err=1 three edges later and stays set until wrstn.
